// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode, strobe-index and state definitions for the ALU operation sequencer.
package alu_op_sequencer_pkg;

    localparam logic [3:0] OpAdd       = 4'd0;
    localparam logic [3:0] OpSub       = 4'd1;
    localparam logic [3:0] OpAnd       = 4'd2;
    localparam logic [3:0] OpOr        = 4'd3;
    localparam logic [3:0] OpXor       = 4'd4;
    localparam logic [3:0] OpInv       = 4'd5;
    localparam logic [3:0] OpClr       = 4'd6;
    localparam logic [3:0] OpLsh       = 4'd7;
    localparam logic [3:0] OpRsh       = 4'd8;
    localparam logic [3:0] OpLastLegal = 4'd8;

    // Bit positions within the one-hot ALU strobe vector
    localparam int unsigned NumStb = 10;
    localparam int unsigned StbAdd = 0;
    localparam int unsigned StbSub = 1;
    localparam int unsigned StbLsr = 2;
    localparam int unsigned StbLsh = 3;
    localparam int unsigned StbRsh = 4;
    localparam int unsigned StbAnd = 5;
    localparam int unsigned StbOr  = 6;
    localparam int unsigned StbXor = 7;
    localparam int unsigned StbInv = 8;
    localparam int unsigned StbClr = 9;

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StResp} state_e;

    typedef enum logic [1:0] {CarryZero, CarryOvf, CarryShift} carry_src_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: execute-phase strobe, shift/legal flags and carry source.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [3:0]        op_i,
    output logic [NumStb-1:0] strobe_o,
    output logic              is_shift_o,
    output logic              is_legal_o,
    output carry_src_e        carry_src_o
);

    always_comb begin
        strobe_o    = '0;
        is_shift_o  = 1'b0;
        is_legal_o  = (op_i <= OpLastLegal);
        carry_src_o = CarryZero;
        case (op_i)
            OpAdd: begin
                strobe_o[StbAdd] = 1'b1;
                carry_src_o      = CarryOvf;
            end
            OpSub: begin
                strobe_o[StbSub] = 1'b1;
                carry_src_o      = CarryOvf;
            end
            OpAnd: strobe_o[StbAnd] = 1'b1;
            OpOr:  strobe_o[StbOr]  = 1'b1;
            OpXor: strobe_o[StbXor] = 1'b1;
            OpInv: strobe_o[StbInv] = 1'b1;
            OpClr: strobe_o[StbClr] = 1'b1;
            OpLsh: begin
                strobe_o[StbLsh] = 1'b1;
                is_shift_o       = 1'b1;
                carry_src_o      = CarryShift;
            end
            OpRsh: begin
                strobe_o[StbRsh] = 1'b1;
                is_shift_o       = 1'b1;
                carry_src_o      = CarryShift;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response front end for the 4-bit ALU: issues registered one-hot strobes,
// runs the load-then-shift sequence for shifts and holds the captured result.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_carry,
    output logic                  resp_zero,
    output logic                  resp_err,
    output logic [CNT_WIDTH-1:0]  op_count,
    output logic                  alu_add,
    output logic                  alu_sub,
    output logic                  alu_lsr,
    output logic                  alu_lsh,
    output logic                  alu_rsh,
    output logic                  alu_and,
    output logic                  alu_or,
    output logic                  alu_xor,
    output logic                  alu_inv,
    output logic                  alu_clr,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_overflow,
    input  logic                  alu_shift_flag
);

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [NumStb-1:0]     strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  carry_q, carry_d, zero_q, zero_d, err_q, err_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic [3:0]        dec_op;
    logic [NumStb-1:0] dec_strobe;
    logic              dec_is_shift, dec_is_legal;
    carry_src_e        dec_carry_src;

    // The decoder sees the live request only while idle; afterwards the latched opcode
    assign dec_op = (state_q == StIdle) ? req_op : op_q;

    alu_op_decode u_decode (
        .op_i        (dec_op),
        .strobe_o    (dec_strobe),
        .is_shift_o  (dec_is_shift),
        .is_legal_o  (dec_is_legal),
        .carry_src_o (dec_carry_src)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        strobe_d = '0;
        in1_d    = in1_q;
        in2_d    = in2_q;
        data_d   = data_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (!dec_is_legal) begin
                        state_d = StResp;
                        data_d  = '0;
                        carry_d = 1'b0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = dec_is_shift ? StLoad : StExec;
                        strobe_d = dec_is_shift ? NumStb'(1) << StbLsr : dec_strobe;
                        in1_d    = req_a;
                        in2_d    = req_b;
                    end
                end
            end
            StLoad: begin
                state_d  = StExec;
                strobe_d = dec_strobe;
                in1_d    = a_q;
                in2_d    = b_q;
            end
            StExec: begin
                state_d = StResp;
                data_d  = alu_out;
                zero_d  = (alu_out == '0);
                err_d   = 1'b0;
                case (dec_carry_src)
                    CarryOvf:   carry_d = alu_overflow;
                    CarryShift: carry_d = alu_shift_flag;
                    default:    carry_d = 1'b0;
                endcase
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                    if (!err_q && (count_q != {CNT_WIDTH{1'b1}})) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            strobe_q <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            data_q   <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            strobe_q <= strobe_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            data_q   <= data_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_data  = data_q;
    assign resp_carry = carry_q;
    assign resp_zero  = zero_q;
    assign resp_err   = err_q;
    assign op_count   = count_q;
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;

    assign alu_add = strobe_q[StbAdd];
    assign alu_sub = strobe_q[StbSub];
    assign alu_lsr = strobe_q[StbLsr];
    assign alu_lsh = strobe_q[StbLsh];
    assign alu_rsh = strobe_q[StbRsh];
    assign alu_and = strobe_q[StbAnd];
    assign alu_or  = strobe_q[StbOr];
    assign alu_xor = strobe_q[StbXor];
    assign alu_inv = strobe_q[StbInv];
    assign alu_clr = strobe_q[StbClr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural model of the 4-bit ALU.
module tb_alu_op_sequencer;

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 2;

    localparam logic [9:0] S_NONE = 10'h000;
    localparam logic [9:0] S_ADD  = 10'h001;
    localparam logic [9:0] S_SUB  = 10'h002;
    localparam logic [9:0] S_LSR  = 10'h004;
    localparam logic [9:0] S_LSH  = 10'h008;
    localparam logic [9:0] S_RSH  = 10'h010;
    localparam logic [9:0] S_AND  = 10'h020;
    localparam logic [9:0] S_OR   = 10'h040;
    localparam logic [9:0] S_XOR  = 10'h080;
    localparam logic [9:0] S_INV  = 10'h100;
    localparam logic [9:0] S_CLR  = 10'h200;

    logic          clk, reset;
    logic          req_valid, req_ready, resp_valid, resp_ready;
    logic [3:0]    req_op;
    logic [DW-1:0] req_a, req_b, resp_data;
    logic          resp_carry, resp_zero, resp_err;
    logic [CW-1:0] op_count;
    logic          alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh;
    logic          alu_and, alu_or, alu_xor, alu_inv, alu_clr;
    logic [DW-1:0] alu_in1, alu_in2, alu_out;
    logic          alu_overflow, alu_shift_flag;
    logic [9:0]    stb;

    int n_checks = 0;
    int n_errors = 0;

    alu_op_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_carry     (resp_carry),
        .resp_zero      (resp_zero),
        .resp_err       (resp_err),
        .op_count       (op_count),
        .alu_add        (alu_add),
        .alu_sub        (alu_sub),
        .alu_lsr        (alu_lsr),
        .alu_lsh        (alu_lsh),
        .alu_rsh        (alu_rsh),
        .alu_and        (alu_and),
        .alu_or         (alu_or),
        .alu_xor        (alu_xor),
        .alu_inv        (alu_inv),
        .alu_clr        (alu_clr),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .alu_out        (alu_out),
        .alu_overflow   (alu_overflow),
        .alu_shift_flag (alu_shift_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign stb = {alu_clr, alu_inv, alu_xor, alu_or, alu_and,
                  alu_rsh, alu_lsh, alu_lsr, alu_sub, alu_add};

    // ALU model: shift register loads on alu_lsr; overflow reports the adder carry even for
    // non-arithmetic ops so that the sequencer's masking is exercised.
    logic [DW-1:0] sr;
    always @(posedge clk) if (alu_lsr) sr <= alu_in1;

    always_comb begin
        logic [DW:0] sum;
        logic [DW:0] dif;
        sum            = {1'b0, alu_in1} + {1'b0, alu_in2};
        dif            = {1'b0, alu_in1} - {1'b0, alu_in2};
        alu_out        = '0;
        alu_overflow   = sum[DW];
        alu_shift_flag = sr[DW-1];
        if (alu_add) alu_out = sum[DW-1:0];
        if (alu_sub) begin
            alu_out      = dif[DW-1:0];
            alu_overflow = dif[DW];
        end
        if (alu_and) alu_out = alu_in1 & alu_in2;
        if (alu_or)  alu_out = alu_in1 | alu_in2;
        if (alu_xor) alu_out = alu_in1 ^ alu_in2;
        if (alu_inv) alu_out = ~alu_in1;
        if (alu_clr) alu_out = '0;
        if (alu_lsh) alu_out = {sr[DW-2:0], 1'b0};
        if (alu_rsh) alu_out = {1'b0, sr[DW-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge and follow it cycle by cycle up to resp_valid.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int lat, input logic [9:0] s1,
                         input logic [9:0] s2, input logic [DW-1:0] d, input logic c,
                         input logic z, input logic e, input logic early_ready);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        resp_ready = early_ready;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_op    = 4'h0;
            chk($sformatf("%s.valid%0d", tag, k), 32'(resp_valid), 32'(k == lat));
            chk($sformatf("%s.stb%0d", tag, k), 32'(stb),
                32'((k == lat) ? S_NONE : ((k == 1) ? s1 : s2)));
            if (k == 1 && lat > 1) chk({tag, ".in1"}, 32'(alu_in1), 32'(a));
            if (k == lat - 1) chk({tag, ".in2"}, 32'(alu_in2), 32'(b));
        end
        chk({tag, ".data"}, 32'(resp_data), 32'(d));
        chk({tag, ".carry"}, 32'(resp_carry), 32'(c));
        chk({tag, ".zero"}, 32'(resp_zero), 32'(z));
        chk({tag, ".err"}, 32'(resp_err), 32'(e));
    endtask

    task automatic take(input string tag, input logic [CW-1:0] cnt);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, ".done_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".count"}, 32'(op_count), 32'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 4'h0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        #3;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.data", 32'(resp_data), 32'd0);
        chk("rst.flags", 32'({resp_carry, resp_zero, resp_err}), 32'd0);
        chk("rst.count", 32'(op_count), 32'd0);
        chk("rst.stb", 32'(stb), 32'(S_NONE));
        chk("rst.in", 32'({alu_in1, alu_in2}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_op("add", 4'd0, 4'h9, 4'h8, 2, S_ADD, S_NONE, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        take("add", 2'd1);
        do_op("ill", 4'hF, 4'h3, 4'h4, 1, S_NONE, S_NONE, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        take("ill", 2'd1);
        do_op("sub", 4'd1, 4'h3, 4'h5, 2, S_SUB, S_NONE, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0);
        take("sub", 2'd2);
        do_op("xor", 4'd4, 4'hA, 4'hA, 2, S_XOR, S_NONE, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        take("xor", 2'd3);
        do_op("lsh", 4'd7, 4'hB, 4'h0, 3, S_LSR, S_LSH, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        take("lsh", 2'd3);
        do_op("rsh", 4'd8, 4'h1, 4'h0, 3, S_LSR, S_RSH, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        take("rsh", 2'd3);

        // Backpressure: result must hold while a competing request waits
        do_op("bp", 4'd0, 4'h2, 4'h3, 2, S_ADD, S_NONE, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_op    = 4'd0;
        req_a     = 4'h1;
        req_b     = 4'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp.hold_valid%0d", i), 32'(resp_valid), 32'd1);
            chk($sformatf("bp.hold_data%0d", i), 32'(resp_data), 32'h5);
            chk($sformatf("bp.hold_ready%0d", i), 32'(req_ready), 32'd0);
            chk($sformatf("bp.hold_stb%0d", i), 32'(stb), 32'(S_NONE));
        end
        take("bp", 2'd3);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp2.stb", 32'(stb), 32'(S_ADD));
        chk("bp2.in", 32'({alu_in1, alu_in2}), 32'h11);
        @(negedge clk);
        chk("bp2.valid", 32'(resp_valid), 32'd1);
        chk("bp2.data", 32'(resp_data), 32'h2);
        take("bp2", 2'd3);

        // Asynchronous reset while the shift register is being loaded
        req_valid = 1'b1;
        req_op    = 4'd8;
        req_a     = 4'h9;
        req_b     = 4'h0;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        chk("arst.lsr", 32'(alu_lsr), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst.stb", 32'(stb), 32'(S_NONE));
        chk("arst.valid", 32'(resp_valid), 32'd0);
        chk("arst.ready", 32'(req_ready), 32'd1);
        chk("arst.count", 32'(op_count), 32'd0);
        chk("arst.in1", 32'(alu_in1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("arst.post_valid", 32'(resp_valid), 32'd0);
        chk("arst.post_ready", 32'(req_ready), 32'd1);
        chk("arst.post_stb", 32'(stb), 32'(S_NONE));

        do_op("and", 4'd2, 4'hC, 4'hA, 2, S_AND, S_NONE, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        take("and", 2'd1);
        do_op("or", 4'd3, 4'hC, 4'hA, 2, S_OR, S_NONE, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        take("or", 2'd2);
        do_op("inv", 4'd5, 4'h5, 4'h0, 2, S_INV, S_NONE, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        take("inv", 2'd3);
        do_op("clr", 4'd6, 4'hF, 4'hF, 2, S_CLR, S_NONE, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        take("clr", 2'd3);
        do_op("ill9", 4'd9, 4'h1, 4'h1, 1, S_NONE, S_NONE, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        take("ill9", 2'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Front-end controller for the 4-bit ArithmeticLogicUnit. It accepts one operation request at a time over a valid/ready handshake and drives the ALU's one-hot control strobes and operands. For shifts it runs the two-cycle shift-register load-then-shift sequence. It captures the result and flags, then holds them on a valid/ready response port until the consumer takes them.

Parameters:
DATA_WIDTH, 4, operand/result width; must match the ALU (only 4 supported)
CNT_WIDTH, 8, width of saturating completed-operation counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request
req_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INV, 6 CLR, 7 LSH, 8 RSH, 9-15 illegal
req_a  in  DATA_WIDTH  operand A (ALU in1)
req_b  in  DATA_WIDTH  operand B (ALU in2)
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_data  out  DATA_WIDTH  captured result
resp_carry  out  1  ALU overflow (ADD/SUB), shiftFlag (LSH/RSH), 0 otherwise
resp_zero  out  1  resp_data == 0
resp_err  out  1  illegal opcode
op_count  out  CNT_WIDTH  completed legal operations, saturating
alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor, alu_inv, alu_clr  out  1 each  ALU control strobes
alu_in1, alu_in2  out  DATA_WIDTH  ALU operands
alu_out  in  DATA_WIDTH  ALU result
alu_overflow  in  1  ALU overflow
alu_shift_flag  in  1  ALU shiftFlag

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous, active-low.
- Reset values:
  - FSM in IDLE.
  - req_ready=1.
  - resp_valid=0, resp_data=0, resp_carry=0, resp_zero=0, resp_err=0.
  - op_count=0.
  - All alu_* strobes 0; alu_in1=alu_in2=0.
- FSM states: IDLE, LOAD, EXEC, RESP.
- IDLE:
  - req_ready=1; strobes all 0.
  - On req_valid&req_ready, latch op/A/B into internal regs.
  - Next state: LOAD for op 7/8, RESP for illegal op, EXEC otherwise.
  - Later changes on req_* are ignored.
- LOAD (shift only, 1 cycle):
  - alu_lsr=1, alu_in1=A.
  - The ALU shift register loads A at this edge.
  - Next state: EXEC.
- EXEC (1 cycle):
  - Exactly one strobe matching the opcode is 1; alu_in1=A, alu_in2=B.
  - At the edge: resp_data<=alu_out; resp_zero<=(alu_out==0); resp_err<=0.
  - resp_carry <= alu_overflow for ADD/SUB, alu_shift_flag for LSH/RSH, 0 otherwise.
  - Next state: RESP.
- Illegal op: no strobe asserted at any point.
  - resp_data=0, resp_zero=1, resp_carry=0, resp_err=1.
  - op_count unchanged.
- RESP:
  - resp_valid=1, req_ready=0, strobes 0.
  - resp_* held stable until resp_valid&resp_ready.
  - On handshake: back to IDLE next cycle; op_count += 1 if not error, saturating at 2^CNT_WIDTH-1.
- Latency, accept edge to resp_valid high: 2 cycles normal, 3 cycles shift, 1 cycle illegal.
- Throughput: no overlap between requests. Minimum spacing between accepts is latency+1 cycles.
- Strobe exclusivity: at most one strobe high in any cycle. All strobes are registered outputs (glitch-free).
- resp_ready high while resp_valid is low has no effect.
- Reset asserted mid-operation (any state): all outputs immediately take reset values, the pending result is discarded, and op_count is cleared.

Decomposition:
- Shared header AluOps.vh holds:
  - opcode constants (OP_ADD..OP_RSH, OP_LAST_LEGAL=8);
  - state encodings.
- One sub-module alu_op_decode: combinational opcode to {10-bit one-hot strobe vector, is_shift, is_legal, carry_src}. The FSM registers its output.

Test Plan:
- ADD A=9,B=8 -> alu_add high for exactly 1 cycle; resp_valid 2 cycles after accept; data=1, carry=1, zero=0, err=0; op_count 0->1.
- SUB A=3,B=5 -> alu_sub 1 cycle; data=0xE, carry=1; XOR A=0xA,B=0xA -> data=0, zero=1, carry=0.
- LSH A=0xB -> alu_lsr 1 cycle with alu_in1=0xB, then alu_lsh 1 cycle; resp_valid 3 cycles after accept; data=0x6, carry=1. RSH A=0x1 -> data=0, carry=0, zero=1.
- Illegal op 0xF -> no strobe ever asserted; resp_valid 1 cycle after accept; err=1, data=0; op_count unchanged.
- Backpressure: ADD 2+3 with resp_ready low 5 cycles -> data=5 stable, req_ready=0 throughout, a new req_valid not accepted; accept occurs in the cycle after the response handshake.
- Reset low during LOAD of an RSH -> strobes drop asynchronously, resp_valid stays 0, req_ready=1 after release. With CNT_WIDTH=2, 5 legal ops -> op_count saturates at 3.
